nand_unit_arbiter: RTL and testbench
====================================

# nand_unit_arbiter

- Round-robin arbiter and sequencer that shares one 4-bit NAND datapath (`nand_gate_4bits`) between `N_REQ` requesters.
- Requesters present operand pairs with a request/grant handshake.
- The block registers each result and returns it, tagged with the requester index, over a valid/ready response channel.
- It sits between the operand-producing units and the shared logic unit, and keeps a saturating count of completed operations.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8).
- `ID_W`, 2, width of requester index; must equal ceil(log2(`N_REQ`)).
- `CNT_W`, 8, width of completed-operation counter.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in `N_REQ`: per-requester request; held high with operands stable until granted.
- `a_in` in `N_REQ`*4: operand A, requester i at bits [4i+3:4i].
- `b_in` in `N_REQ`*4: operand B, same packing.
- `gnt` out `N_REQ`: one-hot (or zero) grant, combinational; `req[i]` & `gnt[i]` in a cycle = accepted.
- `rsp_valid` out 1: result register holds an unconsumed result.
- `rsp_ready` in 1: consumer accepts result when `rsp_valid` & `rsp_ready`.
- `rsp_y` out 4: ~(A & B) of the accepted operation.
- `rsp_id` out `ID_W`: index of the requester that produced `rsp_y`.
- `op_count` out `CNT_W`: number of results consumed, saturating.

## Operation
- Two states:
  - EMPTY: result register free.
  - FULL: `rsp_valid`=1.
- Grant is issued when `req` != 0 and (state EMPTY, or state FULL with `rsp_ready`=1).
  - Otherwise `gnt`=0.
  - Gives one accept per cycle under continuous `rsp_ready`.
- Round-robin selection:
  - Pointer `last` holds the index of the most recent grant.
  - Search order is `last`+1, `last`+2, … wrapping modulo `N_REQ`.
  - The first asserted `req` wins.
  - `last` updates only on an accept.
- On accept, `a_in`/`b_in` of the winner are muxed into `nand_gate_4bits`.
  - Its output is captured into `rsp_y`, the winner index into `rsp_id`, and the state goes FULL.
- On consume (`rsp_valid` & `rsp_ready`) without a simultaneous accept: state goes EMPTY.
  - `rsp_y`/`rsp_id` keep their last value.
- Consume and accept in the same cycle: state stays FULL and the register loads the new result.
- `op_count` increments on each consume and saturates at 2^`CNT_W`-1 (no wrap).
- `req` dropping before grant is legal: the request is withdrawn, with no side effect.

## Timing
- Reset values:
  - `rsp_valid`=0, `rsp_y`=4'b0000, `rsp_id`=0, `op_count`=0.
  - `last`=`N_REQ`-1, so requester 0 has first priority.
  - State EMPTY.
  - `gnt` is driven purely from `req`/state, so it is 0 whenever `req`=0.
- Latency: accept in cycle t, so `rsp_valid`=1 with result visible after the edge ending cycle t (t+1).
- Throughput: 1 result/cycle while `rsp_ready`=1.
- Backpressure: `rsp_ready`=0 in FULL means `gnt`=0; result and id are held stable until consumed.
- `rsp_valid` never deasserts without a consume, except on reset.
- Reset mid-operation: a pending result is discarded, `rsp_valid` falls asynchronously, and the pointer and counter clear.
- `gnt` depends combinationally on `req` and `rsp_ready`; there is no combinational path from `a_in`/`b_in` to any output.

## Structure
- Shared package holds:
  - State encoding constants (EMPTY=0, FULL=1).
  - Fixed datapath width constant `NAND_W`=4.
- Sub-module: one instance of the existing `nand_gate_4bits` as the shared datapath.
- Arbiter logic (rotate, priority pick, one-hot) stays inline; a separate `rr_pick` function is permitted.

## Test plan
1. Reset, then single requester 1 with A=0010, B=0110.
   - Expect `gnt`=0010 for one cycle.
   - Next cycle: `rsp_valid`=1, `rsp_y`=1101, `rsp_id`=1.
   - `op_count`=1 after consume.
2. All four `req` high continuously, `rsp_ready`=1.
   - Grants are 0,1,2,3,0,… one per cycle.
   - `rsp_id` follows the same sequence one cycle later.
3. Backpressure test:
   - Requester 2 sends A=0111, B=0100, with `rsp_ready`=0 for 5 cycles while requester 3 requests.
   - `rsp_y`=1011 and `rsp_id`=2 are held.
   - `gnt`=0 throughout.
   - On `rsp_ready`=1: same-cycle `gnt`=1000, and the next result is from requester 3.
4. Simultaneous consume and accept:
   - Requester 0 sends A=0000, B=1110 while FULL with `rsp_ready`=1.
   - `rsp_valid` stays 1 and next `rsp_y`=1111, `rsp_id`=0.
5. Assert `rst_n`=0 while FULL with a held result.
   - `rsp_valid` drops immediately.
   - After release, priority restarts at requester 0.
6. Run 300 consumes with `CNT_W`=8: `op_count` stops at 255.

Source files
------------

// File: rtl/nand_unit_arbiter_pkg.sv
// Shared constants and state encoding for the NAND arbiter slice.
package nand_unit_arbiter_pkg;

  // Width of the shared NAND datapath
  localparam int NAND_W = 4;

  // Result-register occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/nand_unit_arbiter_nand.sv
// Shared 4-bit NAND datapath.
module nand_gate_4bits
  import nand_unit_arbiter_pkg::*;
(
  input  logic [NAND_W-1:0] a,
  input  logic [NAND_W-1:0] b,
  output logic [NAND_W-1:0] y
);

  assign y = ~(a & b);

endmodule

// File: rtl/nand_unit_arbiter.sv
// Round-robin arbiter in front of one shared NAND unit. Each result is
// registered and returned with its requester id over a valid/ready channel.
module nand_unit_arbiter
  import nand_unit_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*NAND_W-1:0] a_in,
  input  logic [N_REQ*NAND_W-1:0] b_in,
  output logic [N_REQ-1:0]        gnt,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [NAND_W-1:0]       rsp_y,
  output logic [ID_W-1:0]         rsp_id,
  output logic [CNT_W-1:0]        op_count
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ID_W-1:0]     r_last;
  logic [ID_W-1:0]     r_id;
  logic [NAND_W-1:0]   r_y;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_can_accept;
  logic                w_found;
  logic [ID_W-1:0]     w_win_id;
  logic [N_REQ-1:0]    w_gnt;
  logic                w_accept;
  logic                w_consume;
  logic [NAND_W-1:0]   w_a;
  logic [NAND_W-1:0]   w_b;
  logic [NAND_W-1:0]   w_y;

  // The result slot can take a new operation if empty, or if it is being drained this cycle
  assign w_can_accept = (r_state == ST_EMPTY) || rsp_ready;
  assign w_consume    = (r_state == ST_FULL) && rsp_ready;

  // Round-robin pick: scan from last+1 upward, wrapping; first active request wins
  always_comb begin
    w_found  = 1'b0;
    w_win_id = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (int'(r_last) + k) % N_REQ;
      if (!w_found && req[idx]) begin
        w_found  = 1'b1;
        w_win_id = ID_W'(idx);
      end
    end
  end

  // One-hot grant, gated by slot availability
  always_comb begin
    w_gnt = '0;
    if (w_found && w_can_accept) w_gnt[w_win_id] = 1'b1;
  end

  assign gnt      = w_gnt;
  assign w_accept = |(w_gnt & req);

  // Operand mux for the winner
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == w_win_id) begin
        w_a = a_in[i*NAND_W +: NAND_W];
        w_b = b_in[i*NAND_W +: NAND_W];
      end
    end
  end

  nand_gate_4bits u_nand (
    .a (w_a),
    .b (w_b),
    .y (w_y)
  );

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next-state: an accept always fills; a consume alone empties
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL:  if (w_consume && !w_accept) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Result, id and pointer load on accept; held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y    <= '0;
      r_id   <= '0;
      r_last <= ID_W'(N_REQ - 1);
    end else if (w_accept) begin
      r_y    <= w_y;
      r_id   <= w_win_id;
      r_last <= w_win_id;
    end
  end

  // Saturating count of consumed results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_cnt <= '0;
    else if (w_consume && r_cnt != '1)  r_cnt <= r_cnt + 1'b1;
  end

  assign rsp_valid = (r_state == ST_FULL);
  assign rsp_y     = r_y;
  assign rsp_id    = r_id;
  assign op_count  = r_cnt;

endmodule

// File: tb/tb_nand_unit_arbiter.sv
// Directed bench for nand_unit_arbiter (N_REQ=4, ID_W=2, CNT_W=8).
module tb_nand_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [3:0]  rsp_y;
  logic [1:0]  rsp_id;
  logic [7:0]  op_count;

  int vec = 0;
  int err = 0;

  nand_unit_arbiter #(.N_REQ(4), .ID_W(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_id(rsp_id), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req = '0; rsp_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0;
    #3;
    vec++; if (rsp_valid !== 1'b0) begin err++; $display("FAIL reset_valid got %b exp 0", rsp_valid); end
    vec++; if (rsp_y !== 4'b0000) begin err++; $display("FAIL reset_y got %b exp 0000", rsp_y); end
    vec++; if (rsp_id !== 2'd0) begin err++; $display("FAIL reset_id got %0d exp 0", rsp_id); end
    vec++; if (op_count !== 8'd0) begin err++; $display("FAIL reset_count got %0d exp 0", op_count); end
    vec++; if (gnt !== 4'b0000) begin err++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single();
    req = 4'b0010; a_in = 16'h0020; b_in = 16'h0060; rsp_ready = 1'b0;
    #1;
    vec++; if (gnt !== 4'b0010) begin err++; $display("FAIL single_gnt got %b exp 0010", gnt); end
    tick();
    req = '0;
    #1;
    vec++; if (gnt !== 4'b0000) begin err++; $display("FAIL single_gnt_drop got %b exp 0000", gnt); end
    vec++; if (rsp_valid !== 1'b1) begin err++; $display("FAIL single_valid got %b exp 1", rsp_valid); end
    vec++; if (rsp_y !== 4'b1101) begin err++; $display("FAIL single_y got %b exp 1101", rsp_y); end
    vec++; if (rsp_id !== 2'd1) begin err++; $display("FAIL single_id got %0d exp 1", rsp_id); end
    rsp_ready = 1'b1;
    tick();
    vec++; if (rsp_valid !== 1'b0) begin err++; $display("FAIL single_drain got %b exp 0", rsp_valid); end
    vec++; if (op_count !== 8'd1) begin err++; $display("FAIL single_count got %0d exp 1", op_count); end
    vec++; if (rsp_y !== 4'b1101) begin err++; $display("FAIL single_y_hold got %b exp 1101", rsp_y); end
  endtask

  // After reset: all requesters active, grants rotate 0,1,2,3,...
  task automatic test_rr();
    logic [3:0] exp_g;
    logic [3:0] exp_y;
    apply_reset();
    req = 4'b1111; a_in = 16'h3210; b_in = 16'hFFFF; rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_g = 4'b0001 << (k % 4);
      exp_y = ~4'(k % 4);
      #1;
      vec++; if (gnt !== exp_g) begin err++; $display("FAIL rr_gnt[%0d] got %b exp %b", k, gnt, exp_g); end
      tick();
      vec++; if (rsp_id !== 2'(k % 4) || rsp_valid !== 1'b1 || rsp_y !== exp_y) begin
        err++; $display("FAIL rr_rsp[%0d] got v=%b id=%0d y=%b exp v=1 id=%0d y=%b", k, rsp_valid, rsp_id, rsp_y, k % 4, exp_y);
      end
    end
    req = '0;
    tick();
    vec++; if (rsp_valid !== 1'b0) begin err++; $display("FAIL rr_drain got %b exp 0", rsp_valid); end
    vec++; if (op_count !== 8'd8) begin err++; $display("FAIL rr_count got %0d exp 8", op_count); end
  endtask

  // Pointer is at 3 here; requester 2 fills the slot, requester 3 waits behind backpressure
  task automatic test_backpressure();
    req = 4'b0100; a_in = 16'hF700; b_in = 16'hA400; rsp_ready = 1'b0;
    #1;
    vec++; if (gnt !== 4'b0100) begin err++; $display("FAIL bp_gnt2 got %b exp 0100", gnt); end
    tick();
    req = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      #1;
      vec++; if (gnt !== 4'b0000) begin err++; $display("FAIL bp_gnt_stall[%0d] got %b exp 0000", k, gnt); end
      vec++; if (rsp_valid !== 1'b1 || rsp_y !== 4'b1011 || rsp_id !== 2'd2) begin
        err++; $display("FAIL bp_hold[%0d] got v=%b y=%b id=%0d exp v=1 y=1011 id=2", k, rsp_valid, rsp_y, rsp_id);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    vec++; if (gnt !== 4'b1000) begin err++; $display("FAIL bp_release_gnt got %b exp 1000", gnt); end
    tick();
    req = '0;
    vec++; if (rsp_valid !== 1'b1 || rsp_y !== 4'b0101 || rsp_id !== 2'd3) begin
      err++; $display("FAIL bp_next got v=%b y=%b id=%0d exp v=1 y=0101 id=3", rsp_valid, rsp_y, rsp_id);
    end
    tick();
    vec++; if (op_count !== 8'd10) begin err++; $display("FAIL bp_count got %0d exp 10", op_count); end
  endtask

  // Slot FULL (requester 1), then requester 0 accepted in the same cycle the slot drains
  task automatic test_consume_accept();
    req = 4'b0010; a_in = 16'h00F0; b_in = 16'h00F0; rsp_ready = 1'b0;
    tick();
    vec++; if (rsp_valid !== 1'b1 || rsp_y !== 4'b0000 || rsp_id !== 2'd1) begin
      err++; $display("FAIL ca_fill got v=%b y=%b id=%0d exp v=1 y=0000 id=1", rsp_valid, rsp_y, rsp_id);
    end
    req = 4'b0001; a_in = 16'h0000; b_in = 16'h000E; rsp_ready = 1'b1;
    #1;
    vec++; if (gnt !== 4'b0001) begin err++; $display("FAIL ca_gnt got %b exp 0001", gnt); end
    tick();
    req = '0; rsp_ready = 1'b0;
    vec++; if (rsp_valid !== 1'b1 || rsp_y !== 4'b1111 || rsp_id !== 2'd0) begin
      err++; $display("FAIL ca_rsp got v=%b y=%b id=%0d exp v=1 y=1111 id=0", rsp_valid, rsp_y, rsp_id);
    end
    vec++; if (op_count !== 8'd11) begin err++; $display("FAIL ca_count got %0d exp 11", op_count); end
  endtask

  // Reset with a held result: valid drops without a clock edge; priority back to 0
  task automatic test_reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    vec++; if (rsp_valid !== 1'b0) begin err++; $display("FAIL rstmid_valid got %b exp 0", rsp_valid); end
    vec++; if (op_count !== 8'd0 || rsp_y !== 4'b0000) begin
      err++; $display("FAIL rstmid_clear got cnt=%0d y=%b exp cnt=0 y=0000", op_count, rsp_y);
    end
    tick();
    rst_n = 1'b1;
    req = 4'b1111; rsp_ready = 1'b1;
    #1;
    vec++; if (gnt !== 4'b0001) begin err++; $display("FAIL rstmid_prio got %b exp 0001", gnt); end
    req = '0;
    tick();
    tick();
  endtask

  // One requester held with ready high: edge n consumes result n-1
  task automatic test_saturate();
    apply_reset();
    req = 4'b0001; a_in = '0; b_in = '0; rsp_ready = 1'b1;
    for (int n = 1; n <= 301; n++) begin
      tick();
      if (n == 255) begin
        vec++; if (op_count !== 8'd254) begin err++; $display("FAIL sat_254 got %0d exp 254", op_count); end
      end
      if (n == 256) begin
        vec++; if (op_count !== 8'd255) begin err++; $display("FAIL sat_255 got %0d exp 255", op_count); end
      end
      if (n == 257) begin
        vec++; if (op_count !== 8'd255) begin err++; $display("FAIL sat_nowrap got %0d exp 255", op_count); end
      end
    end
    vec++; if (op_count !== 8'd255) begin err++; $display("FAIL sat_final got %0d exp 255", op_count); end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_backpressure();
    test_consume_accept();
    test_reset_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
